// File: rtl/glitc_intercom_echo_monitor.sv
// Echo-link initiator and statistics block: schedules periodic echo requests,
// consumes the handler's ready/seen/latency result and keeps link statistics.
module glitc_intercom_echo_monitor #(
    parameter int LATENCY_WIDTH  = 4,
    parameter int INTERVAL_WIDTH = 16,
    parameter int COUNT_WIDTH    = 8,
    parameter int MISS_LIMIT     = 3,
    parameter int LOCK_HITS      = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic [INTERVAL_WIDTH-1:0] interval_i,
    input  logic                      stats_clear_i,
    output logic                      echo_send_o,
    output logic                      status_rst_o,
    input  logic                      echo_ready_i,
    input  logic                      echo_seen_i,
    input  logic [LATENCY_WIDTH-1:0]  echo_latency_i,
    output logic [LATENCY_WIDTH-1:0]  last_latency_o,
    output logic [LATENCY_WIDTH-1:0]  min_latency_o,
    output logic [LATENCY_WIDTH-1:0]  max_latency_o,
    output logic [COUNT_WIDTH-1:0]    sent_count_o,
    output logic [COUNT_WIDTH-1:0]    seen_count_o,
    output logic [COUNT_WIDTH-1:0]    missed_count_o,
    output logic                      link_ok_o,
    output logic                      busy_o
);

    localparam int WAIT_LIMIT = (1 << LATENCY_WIDTH) + 4;
    localparam int WAIT_W     = LATENCY_WIDTH + 2;
    localparam int HIT_W      = $clog2(LOCK_HITS + 1);
    localparam int MISS_W     = $clog2(MISS_LIMIT + 1);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);
    localparam logic [HIT_W-1:0]  HIT_SAT   = HIT_W'(LOCK_HITS);
    localparam logic [MISS_W-1:0] MISS_SAT  = MISS_W'(MISS_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_WAIT    = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    state_t                    state_r;
    state_t                    state_s;
    logic [WAIT_W-1:0]         wait_cnt_r;
    logic [INTERVAL_WIDTH-1:0] holdoff_r;
    logic                      clr_pend_r;
    logic                      echo_send_r;
    logic                      status_rst_r;
    logic                      busy_r;
    logic [LATENCY_WIDTH-1:0]  last_lat_r;
    logic [LATENCY_WIDTH-1:0]  min_lat_r;
    logic [LATENCY_WIDTH-1:0]  max_lat_r;
    logic [COUNT_WIDTH-1:0]    sent_cnt_r;
    logic [COUNT_WIDTH-1:0]    seen_cnt_r;
    logic [COUNT_WIDTH-1:0]    missed_cnt_r;
    logic [HIT_W-1:0]          hit_streak_r;
    logic [HIT_W-1:0]          hit_streak_s;
    logic [MISS_W-1:0]         miss_streak_r;
    logic [MISS_W-1:0]         miss_streak_s;
    logic                      link_ok_r;

    logic                      wait_exit_s;
    logic                      in_xchg_s;
    logic                      clear_req_s;
    logic                      apply_clear_s;
    logic                      record_s;
    logic                      hit_s;
    logic                      miss_s;
    logic                      sent_inc_s;

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        if (v == {COUNT_WIDTH{1'b1}}) begin
            return v;
        end else begin
            return v + COUNT_WIDTH'(1);
        end
    endfunction

    // Next-state decode of the exchange sequencer.
    always_comb begin
        state_s     = state_r;
        wait_exit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (enable_i) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (echo_ready_i || (wait_cnt_r == WAIT_LAST)) begin
                    state_s     = ST_HOLDOFF;
                    wait_exit_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_HOLDOFF: begin
                if (holdoff_r == {INTERVAL_WIDTH{1'b0}}) begin
                    if (enable_i) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_HOLDOFF;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Result classification; a clear requested during an exchange discards that result.
    always_comb begin
        in_xchg_s     = (state_r == ST_SEND) || (state_r == ST_WAIT);
        clear_req_s   = clr_pend_r || stats_clear_i;
        apply_clear_s = (stats_clear_i && !in_xchg_s) || (wait_exit_s && clear_req_s);
        record_s      = wait_exit_s && !clear_req_s;
        hit_s         = record_s && echo_ready_i && echo_seen_i;
        miss_s        = record_s && !(echo_ready_i && echo_seen_i);
        sent_inc_s    = (state_r == ST_SEND);
    end

    // Hit/miss streak update with saturation.
    always_comb begin
        hit_streak_s  = hit_streak_r;
        miss_streak_s = miss_streak_r;
        if (apply_clear_s) begin
            hit_streak_s  = {HIT_W{1'b0}};
            miss_streak_s = {MISS_W{1'b0}};
        end else if (hit_s) begin
            if (hit_streak_r == HIT_SAT) begin
                hit_streak_s = hit_streak_r;
            end else begin
                hit_streak_s = hit_streak_r + HIT_W'(1);
            end
            miss_streak_s = {MISS_W{1'b0}};
        end else if (miss_s) begin
            if (miss_streak_r == MISS_SAT) begin
                miss_streak_s = miss_streak_r;
            end else begin
                miss_streak_s = miss_streak_r + MISS_W'(1);
            end
            hit_streak_s = {HIT_W{1'b0}};
        end else begin
            hit_streak_s  = hit_streak_r;
            miss_streak_s = miss_streak_r;
        end
    end

    // Sequencer state, timers and registered handshake outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_r      <= ST_IDLE;
            wait_cnt_r   <= {WAIT_W{1'b0}};
            holdoff_r    <= {INTERVAL_WIDTH{1'b0}};
            clr_pend_r   <= 1'b0;
            echo_send_r  <= 1'b0;
            status_rst_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            echo_send_r  <= (state_s == ST_SEND);
            busy_r       <= (state_s == ST_SEND) || (state_s == ST_WAIT);
            status_rst_r <= apply_clear_s;
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= {WAIT_W{1'b0}};
            end
            if (wait_exit_s) begin
                holdoff_r <= interval_i;
            end else if ((state_r == ST_HOLDOFF) && (holdoff_r != {INTERVAL_WIDTH{1'b0}})) begin
                holdoff_r <= holdoff_r - INTERVAL_WIDTH'(1);
            end else begin
                holdoff_r <= holdoff_r;
            end
            if (wait_exit_s) begin
                clr_pend_r <= 1'b0;
            end else if (stats_clear_i && in_xchg_s) begin
                clr_pend_r <= 1'b1;
            end else begin
                clr_pend_r <= clr_pend_r;
            end
        end
    end

    // Statistics registers; a clear takes priority over any increment.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_lat_r    <= {LATENCY_WIDTH{1'b0}};
            min_lat_r     <= {LATENCY_WIDTH{1'b1}};
            max_lat_r     <= {LATENCY_WIDTH{1'b0}};
            sent_cnt_r    <= {COUNT_WIDTH{1'b0}};
            seen_cnt_r    <= {COUNT_WIDTH{1'b0}};
            missed_cnt_r  <= {COUNT_WIDTH{1'b0}};
            hit_streak_r  <= {HIT_W{1'b0}};
            miss_streak_r <= {MISS_W{1'b0}};
            link_ok_r     <= 1'b0;
        end else begin
            hit_streak_r  <= hit_streak_s;
            miss_streak_r <= miss_streak_s;
            if (apply_clear_s) begin
                last_lat_r   <= {LATENCY_WIDTH{1'b0}};
                min_lat_r    <= {LATENCY_WIDTH{1'b1}};
                max_lat_r    <= {LATENCY_WIDTH{1'b0}};
                sent_cnt_r   <= {COUNT_WIDTH{1'b0}};
                seen_cnt_r   <= {COUNT_WIDTH{1'b0}};
                missed_cnt_r <= {COUNT_WIDTH{1'b0}};
                link_ok_r    <= 1'b0;
            end else begin
                if (sent_inc_s) begin
                    sent_cnt_r <= sat_inc(sent_cnt_r);
                end
                if (hit_s) begin
                    last_lat_r <= echo_latency_i;
                    seen_cnt_r <= sat_inc(seen_cnt_r);
                    if (echo_latency_i < min_lat_r) begin
                        min_lat_r <= echo_latency_i;
                    end
                    if (echo_latency_i > max_lat_r) begin
                        max_lat_r <= echo_latency_i;
                    end
                end
                if (miss_s) begin
                    missed_cnt_r <= sat_inc(missed_cnt_r);
                end
                if (hit_s && (hit_streak_s == HIT_SAT)) begin
                    link_ok_r <= 1'b1;
                end else if (miss_s && (miss_streak_s == MISS_SAT)) begin
                    link_ok_r <= 1'b0;
                end
            end
        end
    end

    assign echo_send_o    = echo_send_r;
    assign status_rst_o   = status_rst_r;
    assign busy_o         = busy_r;
    assign last_latency_o = last_lat_r;
    assign min_latency_o  = min_lat_r;
    assign max_latency_o  = max_lat_r;
    assign sent_count_o   = sent_cnt_r;
    assign seen_count_o   = seen_cnt_r;
    assign missed_count_o = missed_cnt_r;
    assign link_ok_o      = link_ok_r;

endmodule

// File: tb/tb_glitc_intercom_echo_monitor.sv
// Directed bench for glitc_intercom_echo_monitor: a table of per-exchange handler
// responses with expected statistics, plus sequences for clear/enable/reset/saturation.
module tb_glitc_intercom_echo_monitor;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [15:0] interval_i = 16'd0;
    logic        stats_clear_i = 1'b0;
    logic        echo_send_o;
    logic        status_rst_o;
    logic        echo_ready_i = 1'b0;
    logic        echo_seen_i = 1'b0;
    logic [3:0]  echo_latency_i = 4'd0;
    logic [3:0]  last_latency_o;
    logic [3:0]  min_latency_o;
    logic [3:0]  max_latency_o;
    logic [7:0]  sent_count_o;
    logic [7:0]  seen_count_o;
    logic [7:0]  missed_count_o;
    logic        link_ok_o;
    logic        busy_o;

    int n_vec = 0;
    int n_bad = 0;

    glitc_intercom_echo_monitor dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .enable_i       (enable_i),
        .interval_i     (interval_i),
        .stats_clear_i  (stats_clear_i),
        .echo_send_o    (echo_send_o),
        .status_rst_o   (status_rst_o),
        .echo_ready_i   (echo_ready_i),
        .echo_seen_i    (echo_seen_i),
        .echo_latency_i (echo_latency_i),
        .last_latency_o (last_latency_o),
        .min_latency_o  (min_latency_o),
        .max_latency_o  (max_latency_o),
        .sent_count_o   (sent_count_o),
        .seen_count_o   (seen_count_o),
        .missed_count_o (missed_count_o),
        .link_ok_o      (link_ok_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // d = WAIT cycle in which ready is pulsed; d = 0 means the handler never answers.
    typedef struct {
        int         d;
        logic       sn;
        logic [3:0] lat;
        logic [3:0] e_last;
        logic [3:0] e_min;
        logic [3:0] e_max;
        logic [7:0] e_seen;
        logic [7:0] e_missed;
        logic       e_link;
    } vec_t;

    vec_t vt[13];

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns ticks until echo_send_o is seen, or -1 if the bound expires.
    task automatic wait_send(output int gap);
        gap = 0;
        while (!echo_send_o && gap < 200) begin
            tick;
            gap++;
        end
        if (!echo_send_o) begin
            gap = -1;
        end
    endtask

    task automatic do_exchange(input int d, input logic sn, input logic [3:0] lat,
                               input logic drop_en, output int gap, output int wcyc);
        int n;
        wcyc = 0;
        wait_send(gap);
        if (gap >= 0) begin
            if (drop_en) begin
                enable_i = 1'b0;
            end
            if (d > 0) begin
                for (int i = 1; i <= d; i++) begin
                    tick;
                end
                echo_ready_i   = 1'b1;
                echo_seen_i    = sn;
                echo_latency_i = lat;
                tick;
                echo_ready_i   = 1'b0;
                echo_seen_i    = 1'b0;
                wcyc = d;
            end else begin
                n = 0;
                while (busy_o && n < 100) begin
                    tick;
                    n++;
                end
                wcyc = n - 1;
            end
        end
    endtask

    initial begin
        int gap;
        int wcyc;
        int sends;
        int bad_gaps;

        //          d  sn    lat    last   min    max    seen   missed link
        vt[0]  = '{5, 1'b1, 4'd5,  4'd5,  4'd5,  4'd5,  8'd1,  8'd0, 1'b0};
        vt[1]  = '{5, 1'b1, 4'd5,  4'd5,  4'd5,  4'd5,  8'd2,  8'd0, 1'b0};
        vt[2]  = '{5, 1'b1, 4'd5,  4'd5,  4'd5,  4'd5,  8'd3,  8'd0, 1'b0};
        vt[3]  = '{5, 1'b1, 4'd5,  4'd5,  4'd5,  4'd5,  8'd4,  8'd0, 1'b1};
        vt[4]  = '{5, 1'b1, 4'd7,  4'd7,  4'd5,  4'd7,  8'd5,  8'd0, 1'b1};
        vt[5]  = '{5, 1'b1, 4'd3,  4'd3,  4'd3,  4'd7,  8'd6,  8'd0, 1'b1};
        vt[6]  = '{5, 1'b1, 4'd9,  4'd9,  4'd3,  4'd9,  8'd7,  8'd0, 1'b1};
        vt[7]  = '{5, 1'b1, 4'd3,  4'd3,  4'd3,  4'd9,  8'd8,  8'd0, 1'b1};
        vt[8]  = '{3, 1'b0, 4'd1,  4'd3,  4'd3,  4'd9,  8'd8,  8'd1, 1'b1};
        vt[9]  = '{0, 1'b0, 4'd0,  4'd3,  4'd3,  4'd9,  8'd8,  8'd2, 1'b1};
        vt[10] = '{0, 1'b0, 4'd0,  4'd3,  4'd3,  4'd9,  8'd8,  8'd3, 1'b0};
        vt[11] = '{1, 1'b1, 4'd0,  4'd0,  4'd0,  4'd9,  8'd9,  8'd3, 1'b0};
        vt[12] = '{2, 1'b1, 4'd15, 4'd15, 4'd0,  4'd15, 8'd10, 8'd3, 1'b0};

        tick;
        tick;
        chk("rst send", echo_send_o, 0);
        chk("rst status_rst", status_rst_o, 0);
        chk("rst busy", busy_o, 0);
        chk("rst min", min_latency_o, 15);
        chk("rst max", max_latency_o, 0);
        chk("rst sent", sent_count_o, 0);
        chk("rst link", link_ok_o, 0);

        rst_n_i    = 1'b1;
        enable_i   = 1'b1;
        interval_i = 16'd10;
        for (int i = 0; i < 13; i++) begin
            do_exchange(vt[i].d, vt[i].sn, vt[i].lat, 1'b0, gap, wcyc);
            chk($sformatf("v%0d gap", i), gap, (i == 0) ? 32'd1 : 32'd11);
            if (vt[i].d == 0) begin
                chk($sformatf("v%0d wait cycles", i), wcyc, 20);
            end
            chk($sformatf("v%0d last", i), last_latency_o, vt[i].e_last);
            chk($sformatf("v%0d min", i), min_latency_o, vt[i].e_min);
            chk($sformatf("v%0d max", i), max_latency_o, vt[i].e_max);
            chk($sformatf("v%0d seen", i), seen_count_o, vt[i].e_seen);
            chk($sformatf("v%0d missed", i), missed_count_o, vt[i].e_missed);
            chk($sformatf("v%0d link", i), link_ok_o, vt[i].e_link);
            chk($sformatf("v%0d sent", i), sent_count_o, i + 1);
        end

        // Clear requested two cycles into WAIT stays pending until the exchange ends.
        interval_i = 16'd2;
        wait_send(gap);
        chk("B gap", gap, 11);
        tick;
        tick;
        stats_clear_i = 1'b1;
        tick;
        stats_clear_i = 1'b0;
        chk("B status_rst early", status_rst_o, 0);
        tick;
        tick;
        chk("B status_rst wait", status_rst_o, 0);
        chk("B busy", busy_o, 1);
        echo_ready_i   = 1'b1;
        echo_seen_i    = 1'b1;
        echo_latency_i = 4'd4;
        tick;
        echo_ready_i = 1'b0;
        echo_seen_i  = 1'b0;
        chk("B status_rst", status_rst_o, 1);
        chk("B sent", sent_count_o, 0);
        chk("B seen", seen_count_o, 0);
        chk("B missed", missed_count_o, 0);
        chk("B min", min_latency_o, 15);
        chk("B max", max_latency_o, 0);
        chk("B last", last_latency_o, 0);
        chk("B link", link_ok_o, 0);
        tick;
        chk("B status_rst end", status_rst_o, 0);

        // Ready outside WAIT is ignored; clear in HOLDOFF applies on the next edge.
        do_exchange(2, 1'b1, 4'd4, 1'b0, gap, wcyc);
        chk("C gap", gap, 2);
        chk("C seen", seen_count_o, 1);
        chk("C min", min_latency_o, 4);
        chk("C sent", sent_count_o, 1);
        echo_ready_i   = 1'b1;
        echo_seen_i    = 1'b1;
        echo_latency_i = 4'd1;
        tick;
        echo_ready_i = 1'b0;
        echo_seen_i  = 1'b0;
        chk("C stray seen", seen_count_o, 1);
        chk("C stray last", last_latency_o, 4);
        stats_clear_i = 1'b1;
        tick;
        stats_clear_i = 1'b0;
        chk("C status_rst", status_rst_o, 1);
        chk("C clr seen", seen_count_o, 0);
        chk("C clr min", min_latency_o, 15);
        chk("C clr sent", sent_count_o, 0);

        // Enable dropped during SEND: result recorded, then idle.
        do_exchange(3, 1'b1, 4'd6, 1'b1, gap, wcyc);
        chk("D gap", gap, 1);
        chk("D seen", seen_count_o, 1);
        chk("D last", last_latency_o, 6);
        chk("D sent", sent_count_o, 1);
        sends = 0;
        for (int i = 0; i < 40; i++) begin
            tick;
            if (echo_send_o) begin
                sends++;
            end
        end
        chk("D extra sends", sends, 0);
        chk("D busy", busy_o, 0);

        // Reset in the middle of WAIT.
        enable_i = 1'b1;
        wait_send(gap);
        chk("E gap", gap, 1);
        tick;
        tick;
        chk("E busy", busy_o, 1);
        rst_n_i = 1'b0;
        tick;
        rst_n_i = 1'b1;
        chk("E busy rst", busy_o, 0);
        chk("E send rst", echo_send_o, 0);
        chk("E sent rst", sent_count_o, 0);
        chk("E seen rst", seen_count_o, 0);
        chk("E last rst", last_latency_o, 0);
        chk("E min rst", min_latency_o, 15);
        chk("E max rst", max_latency_o, 0);

        // 300 back-to-back hits saturate the counters.
        interval_i = 16'd0;
        bad_gaps = 0;
        for (int i = 0; i < 300; i++) begin
            do_exchange(1, 1'b1, 4'd2, 1'b0, gap, wcyc);
            if (gap != 1) begin
                bad_gaps++;
            end
            if (gap < 0) begin
                break;
            end
        end
        chk("F gaps", bad_gaps, 0);
        chk("F sent", sent_count_o, 255);
        chk("F seen", seen_count_o, 255);
        chk("F missed", missed_count_o, 0);
        chk("F link", link_ok_o, 1);
        chk("F last", last_latency_o, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/glitc_intercom_echo_monitor.md
Name: glitc_intercom_echo_monitor

Overview:
- Initiator and statistics side of the intercom echo link. Schedules periodic echo requests to the echo handler and consumes its ready/seen/latency result.
- Keeps last/min/max latency, sent/seen/missed counters and a hysteretic link-OK flag for the GLITC status registers.
- Sits between the register interface and the echo handler, all in the intercom clock domain.

Parameters:
- LATENCY_WIDTH, 4: width of the latency value from the echo handler.
- INTERVAL_WIDTH, 16: width of the programmable holdoff between requests.
- COUNT_WIDTH, 8: width of the sent/seen/missed counters (saturating).
- MISS_LIMIT, 3: consecutive misses that drop link_ok_o.
- LOCK_HITS, 4: consecutive hits that raise link_ok_o.

Ports:
- clk_i  in  1  intercom clock; single clock domain.
- rst_n_i  in  1  synchronous, active-low reset.
- enable_i  in  1  level; 1 = run periodic echo requests.
- interval_i  in  INTERVAL_WIDTH  holdoff cycles between exchanges.
- stats_clear_i  in  1  pulse; clear statistics and the handler status.
- echo_send_o  out  1  one-cycle request pulse to the handler's echo_send_i.
- status_rst_o  out  1  one-cycle pulse to the handler's status_rst_i.
- echo_ready_i  in  1  handler result-valid pulse.
- echo_seen_i  in  1  handler flag: echo returned.
- echo_latency_i  in  LATENCY_WIDTH  handler latency count.
- last_latency_o  out  LATENCY_WIDTH  latency of the most recent hit.
- min_latency_o  out  LATENCY_WIDTH  minimum latency over hits.
- max_latency_o  out  LATENCY_WIDTH  maximum latency over hits.
- sent_count_o, seen_count_o, missed_count_o  out  COUNT_WIDTH each  exchange counters.
- link_ok_o  out  1  hysteretic link-good flag.
- busy_o  out  1  exchange in flight (SEND or WAIT).

Behaviour:
- Reset (rst_n_i=0 at an edge) puts the FSM in IDLE and sets every output to 0, except min_latency_o, which resets to all ones. Clear state and streak counters also reset to 0.
- FSM states are IDLE, SEND, WAIT, HOLDOFF.
- IDLE: when enable_i=1, go to SEND on the next edge.
- SEND: echo_send_o=1 for exactly this one registered cycle. sent_count increments. Go to WAIT.
- WAIT:
  - Exit on echo_ready_i=1, or on timeout after 2^LATENCY_WIDTH+4 cycles in WAIT with no ready.
  - Timeout counts as a miss.
  - On exit, load the holdoff counter with interval_i and go to HOLDOFF.
- Hit (ready=1 and seen=1) in the exit cycle:
  - last_latency = echo_latency_i.
  - min/max updated with unsigned compare; equal values leave them unchanged.
  - seen_count increments.
  - Hit streak increments (saturating at LOCK_HITS); miss streak clears.
- Miss (ready with seen=0, or timeout):
  - missed_count increments.
  - Miss streak increments (saturating at MISS_LIMIT); hit streak clears.
  - Latency outputs are not touched.
- link_ok_o:
  - Sets on the edge where the hit streak reaches LOCK_HITS.
  - Clears on the edge where the miss streak reaches MISS_LIMIT.
  - Otherwise holds.
- HOLDOFF:
  - Decrement each cycle. At count 0, go to SEND if enable_i=1, else IDLE.
  - interval_i=0 gives exactly one HOLDOFF cycle.
- enable_i deasserted during SEND or WAIT: the exchange completes and is recorded, then the FSM goes to IDLE via HOLDOFF.
- All counters saturate at all ones and never wrap.
- stats_clear_i outside SEND/WAIT, next edge:
  - Clear the counters, last/max latency, the streaks and link_ok.
  - min_latency returns to all ones.
  - status_rst_o pulses for 1 cycle.
- stats_clear_i during SEND/WAIT:
  - The request is latched as pending.
  - When the exchange exits WAIT, its result is discarded, the clear is applied and status_rst_o pulses in that cycle.
  - status_rst_o is never asserted while the handler is waiting.
- Simultaneous stats_clear_i and a counter increment: the clear wins and the counter ends at 0.
- echo_ready_i outside WAIT is ignored.
- busy_o = 1 in SEND and WAIT.

Test Plan:
- Reset, then enable_i=1, interval_i=10, handler model returning seen=1 with latency 5:
  - echo_send_o pulses every 10+1+1+5-ish cycles with a constant period.
  - last=min=max=5.
  - link_ok_o=1 after the 4th hit.
- Latencies 7, 3, 9, 3 on successive exchanges -> min=3, max=9, last=3, seen_count=4, missed_count=0.
- Handler never asserts ready -> timeout after 20 cycles in WAIT (LATENCY_WIDTH=4). missed_count increments per exchange. link_ok_o falls exactly at the 3rd consecutive miss after lock.
- stats_clear_i pulsed 2 cycles into WAIT:
  - No status_rst_o until ready arrives; then status_rst_o=1 for 1 cycle.
  - All counters are 0, min=all ones, and that exchange is not counted.
- sent_count driven through 300 exchanges with COUNT_WIDTH=8 -> holds at 255.
- Reset asserted mid-WAIT and enable_i dropped mid-exchange:
  - Reset mid-WAIT: all outputs return to reset values.
  - enable_i dropped mid-exchange: that result is recorded, then IDLE with no further echo_send_o.
